// File: rtl/simple_cic_interp.sv
// Single-stage CIC interpolator: comb at the low (g_in) rate, zero-stuff and
// integrate at the high (g_hi) rate, cic_n gated output samples per input.
// Optional build macro SIMPLE_CIC_INTERP_FREERUN_EN: every g_hi produces an
// output strobe, including while idle (integrator holds).
module simple_cic_interp #(
   parameter int unsigned in_width  = 16,
   parameter int unsigned out_width = 18,
   parameter int unsigned cic_n     = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        g_in,
   input  logic signed [in_width-1:0]  d_in,
   input  logic                        g_hi,
   output logic                        g_out,
   output logic signed [out_width-1:0] d_out,
   output logic                        overrun
);

   localparam int unsigned CW = $clog2(cic_n) + 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t                      state;
   logic signed [out_width-1:0] integrator;
   logic signed [out_width-1:0] pending;
   logic signed [in_width-1:0]  prev_in;
   logic [CW-1:0]               count;

   logic signed [in_width:0]    diff_c;
   logic signed [out_width-1:0] pending_eff_c;
   logic signed [out_width-1:0] integ_nxt_c;
   logic [CW-1:0]               count_eff_c;
   logic                        tick_c;
   logic                        first_c;
   logic                        last_c;
   logic                        emit_c;

   // Comb difference, effective pending impulse and tick qualification
   always_comb begin
      diff_c        = {d_in[in_width-1], d_in} - {prev_in[in_width-1], prev_in};
      pending_eff_c = pending;
      if (g_in)
         pending_eff_c = pending + out_width'(diff_c);
      // A g_in restarts the burst, so a same-cycle tick is tick 0
      count_eff_c   = g_in ? '0 : count;
      tick_c        = g_hi && (g_in || (state == BURST));
      first_c       = (count_eff_c == '0);
      last_c        = (count_eff_c == CW'(cic_n - 1));
      integ_nxt_c   = integrator;
      if (tick_c && first_c)
         integ_nxt_c = integrator + pending_eff_c;
`ifdef SIMPLE_CIC_INTERP_FREERUN_EN
      emit_c        = g_hi;
`else
      emit_c        = tick_c;
`endif
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         integrator <= '0;
         pending    <= '0;
         prev_in    <= '0;
         overrun    <= 1'b0;
         g_out      <= 1'b0;
         d_out      <= '0;
      end else begin
         if (g_in)
            prev_in <= d_in;

         // The impulse is consumed only on the first tick of a burst
         if (tick_c && first_c)
            pending <= '0;
         else
            pending <= pending_eff_c;

         integrator <= integ_nxt_c;

         if (g_in && (state == BURST))
            overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (tick_c) begin
                  state <= BURST;
                  count <= count_eff_c + CW'(1);
               end else if (g_in) begin
                  state <= BURST;
                  count <= '0;
               end
            end
            BURST: begin
               if (tick_c) begin
                  if (last_c) begin
                     state <= IDLE;
                     count <= '0;
                  end else begin
                     count <= count_eff_c + CW'(1);
                  end
               end else if (g_in) begin
                  count <= '0;
               end
            end
            default: begin
               state <= IDLE;
               count <= '0;
            end
         endcase

         g_out <= emit_c;
         if (emit_c)
            d_out <= integ_nxt_c;
      end
   end

endmodule

// File: tb/tb_simple_cic_interp.sv
// Directed scoreboard bench for simple_cic_interp (cic_n=4, 16 -> 18 bits).
module tb_simple_cic_interp;

   logic               clk = 1'b0;
   logic               reset;
   logic               g_in;
   logic signed [15:0] d_in;
   logic               g_hi;
   logic               g_out;
   logic signed [17:0] d_out;
   logic               overrun;

   typedef struct {
      logic signed [17:0] val;
      int                 cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   simple_cic_interp #(.in_width(16), .out_width(18), .cic_n(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .g_in    (g_in),
      .d_in    (d_in),
      .g_hi    (g_hi),
      .g_out   (g_out),
      .d_out   (d_out),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: every strobe must match the head of the scoreboard
   always @(negedge clk) begin
      if (g_out) begin
         checks++;
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            assert (d_out === e.val && cyc === e.cyc) else begin
               errors++;
               $error("FAIL strobe: d_out=%0d at cycle %0d, expected %0d at cycle %0d",
                      d_out, cyc, e.val, e.cyc);
            end
         end else begin
            assert (g_out === 1'b0) else begin
               errors++;
               $error("FAIL spurious_g_out: g_out=%0b d_out=%0d at cycle %0d, expected no strobe",
                      g_out, d_out, cyc);
            end
         end
      end
   end

   // One cycle of stimulus; tick says the design must emit ev next cycle
   task automatic drive(input logic gi, input logic signed [15:0] di, input logic gh,
                        input bit tick, input logic signed [17:0] ev);
      exp_t e;
      bit   emit;
      g_in = gi;
      d_in = di;
      g_hi = gh;
      emit = tick;
`ifdef SIMPLE_CIC_INTERP_FREERUN_EN
      emit = gh;
`endif
      if (emit) begin
         e.val = ev;
         e.cyc = cyc + 1;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      g_in = 1'b0;
      g_hi = 1'b0;
      d_in = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 16'sd0, 1'b0, 1'b0, 18'sd0);
   endtask

   // cic_n burst ticks each separated by gap idle cycles
   task automatic burst(input int n, input int gap, input logic signed [17:0] v);
      for (int i = 0; i < n; i++) begin
         idle(gap);
         drive(1'b0, 16'sd0, 1'b1, 1'b1, v);
      end
   endtask

   task automatic check_bit(input string tag, input logic got, input logic want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: got %0b, expected %0b", tag, got, want);
      end
   endtask

   task automatic check_empty(input string tag);
      idle(2);
      checks++;
      assert (exp_q.size() === 0) else begin
         errors++;
         $error("FAIL %s: %0d strobes missing, expected 0", tag, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      reset = 1'b0;
      g_in  = 1'b0;
      g_hi  = 1'b0;
      d_in  = '0;

      // Reset state
      do_reset();
      check_bit("reset_g_out", g_out, 1'b0);
      checks++;
      assert (d_out === 18'sd0) else begin
         errors++;
         $error("FAIL reset_d_out: got %0d, expected 0", d_out);
      end
      check_bit("reset_overrun", overrun, 1'b0);

      // Single sample, g_hi every third cycle
      drive(1'b1, 16'sd100, 1'b0, 1'b0, 18'sd0);
      burst(4, 2, 18'sd100);
      drive(1'b0, 16'sd0, 1'b1, 1'b0, 18'sd100);
      check_empty("t1_count");
      check_bit("t1_overrun", overrun, 1'b0);

      // Full-scale sample sequence
      do_reset();
      drive(1'b1, 16'sd100, 1'b0, 1'b0, 18'sd0);
      burst(4, 1, 18'sd100);
      drive(1'b1, -16'sd50, 1'b0, 1'b0, 18'sd100);
      burst(4, 1, -18'sd50);
      drive(1'b1, 16'sd32767, 1'b0, 1'b0, -18'sd50);
      burst(4, 1, 18'sd32767);
      drive(1'b1, -16'sd32768, 1'b0, 1'b0, 18'sd32767);
      burst(4, 1, -18'sd32768);
      check_empty("t2_count");
      check_bit("t2_overrun", overrun, 1'b0);

      // Overrun: restart after two ticks
      do_reset();
      drive(1'b1, 16'sd5, 1'b0, 1'b0, 18'sd0);
      burst(2, 1, 18'sd5);
      drive(1'b1, 16'sd7, 1'b0, 1'b0, 18'sd5);
      check_bit("t3_overrun_set", overrun, 1'b1);
      burst(4, 1, 18'sd7);
      drive(1'b0, 16'sd0, 1'b1, 1'b0, 18'sd7);
      check_empty("t3_count");
      check_bit("t3_overrun_sticky", overrun, 1'b1);

      // Two inputs with no tick between them
      do_reset();
      drive(1'b1, 16'sd3, 1'b0, 1'b0, 18'sd0);
      drive(1'b1, 16'sd9, 1'b0, 1'b0, 18'sd0);
      burst(4, 1, 18'sd9);
      check_empty("t4_count");
      check_bit("t4_overrun", overrun, 1'b1);

      // Same-cycle g_in and g_hi from idle
      do_reset();
      drive(1'b1, 16'sd20, 1'b1, 1'b1, 18'sd20);
      burst(3, 1, 18'sd20);
      drive(1'b0, 16'sd0, 1'b1, 1'b0, 18'sd20);
      check_empty("t5_count");
      check_bit("t5_overrun", overrun, 1'b0);

      // Reset mid-burst aborts; g_hi ignored until next g_in
      do_reset();
      drive(1'b1, 16'sd50, 1'b1, 1'b1, 18'sd50);
      idle(1);
      reset = 1'b1;
      drive(1'b0, 16'sd0, 1'b1, 1'b0, 18'sd0);
      reset = 1'b0;
      check_bit("t6_g_out_after_reset", g_out, 1'b0);
      checks++;
      assert (d_out === 18'sd0) else begin
         errors++;
         $error("FAIL t6_d_out_after_reset: got %0d, expected 0", d_out);
      end
      idle(1);
      drive(1'b0, 16'sd0, 1'b1, 1'b0, 18'sd0);
      check_empty("t6_idle");
      drive(1'b1, 16'sd11, 1'b0, 1'b0, 18'sd0);
      burst(4, 1, 18'sd11);
      check_empty("t6_count");
      check_bit("t6_overrun", overrun, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
